gnss_acq_scheduler: RTL and testbench

- Hardware acquisition scheduler that drives the shared search engine without per-SV CPU intervention.
- Walks a software-supplied SV mask round-robin and picks the lowest free tracking channel.
- Issues the search start / SV / channel handshake, waits for completion, and compares the peak correlation against a threshold.
- On success it marks the channel allocated and reports the hit. Sits between the AHB satellite register block (config and status) and the search engine.

---
 rtl/common_gnss_types_pkg.sv | 28 ++
 rtl/gnss_prio_encoder.sv | 20 ++
 rtl/gnss_acq_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_gnss_acq_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_gnss_types_pkg.sv
// Shared GNSS baseband types: SV index type, acquisition scheduler states
// and the default search timeout.
package common_gnss_types_pkg;

    localparam int SV_W = 5;
    typedef logic [SV_W-1:0] sv_t;

    localparam int ACQ_TIMEOUT_DEFAULT = 32'd16777216;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PICK_CHAN = 3'd1,
        PICK_SV   = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        EVAL      = 3'd5
    } acq_sched_state_t;

    // Round-robin successor of an SV index, wrapping at num_sv-1.
    function automatic sv_t sv_next(input sv_t cur, input int num_sv);
        if (cur == sv_t'(num_sv - 1)) begin
            return sv_t'(0);
        end else begin
            return cur + sv_t'(1);
        end
    endfunction

endpackage

// File: rtl/gnss_prio_encoder.sv
// Lowest-set-bit finder: idx is the lowest asserted request, valid flags any request.
module gnss_prio_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 6
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = req[i] ? IDX_W'(i) : idx;
        end
        valid = |req;
    end

endmodule

// File: rtl/gnss_acq_scheduler.sv
// Acquisition scheduler: walks the SV mask round-robin, drives the shared
// search engine for the lowest free channel and records successful hits.
module gnss_acq_scheduler
    import common_gnss_types_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int NUM_SV         = 32,
    parameter int SEARCH_TIMEOUT = ACQ_TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    enable,
    input  logic [NUM_SV-1:0]       sv_mask,
    input  logic [31:0]             corr_threshold,
    input  logic [NUM_CHANNELS-1:0] chan_release,
    input  logic                    search_busy,
    input  logic                    search_done,
    input  logic [31:0]             search_corr,
    input  logic [5:0]              search_channel_in,
    output logic                    search_start,
    output sv_t                     search_sv,
    output logic [5:0]              search_channel,
    output logic [NUM_CHANNELS-1:0] chan_alloc,
    output logic [NUM_SV-1:0]       sv_acquired,
    output logic                    acq_valid,
    output sv_t                     acq_sv,
    output logic [5:0]              acq_channel,
    output logic [31:0]             acq_corr,
    output logic                    timeout_err,
    output logic                    sweep_idle,
    output logic                    busy
);

    localparam int CNT_W = $clog2(SEARCH_TIMEOUT + 1);

    acq_sched_state_t state_r, state_s;
    logic [5:0]              target_r;
    sv_t                     sv_ptr_r;
    sv_t                     scan_cnt_r;
    logic [CNT_W-1:0]        tmo_cnt_r;
    logic [31:0]             corr_r;
    sv_t                     chan_sv_r [NUM_CHANNELS];
    logic                    enable_q_r;
    logic [NUM_SV-1:0]       sv_mask_q_r;

    logic [5:0]              free_idx_s;
    logic                    free_valid_s;
    logic                    sv_elig_s, tmo_hit_s, mask_chg_s, acq_hit_s;
    logic                    pick_s, scan_step_s, sv_found_s, sweep_end_s;
    logic                    start_ack_s, timeout_s, done_ok_s, eval_s;
    logic [NUM_CHANNELS-1:0] rel_s, alloc_set_s;
    logic [NUM_SV-1:0]       sv_clr_s, sv_set_s;

    gnss_prio_encoder #(
        .WIDTH (NUM_CHANNELS),
        .IDX_W (6)
    ) u_chan_pick (
        .req   (~chan_alloc),
        .idx   (free_idx_s),
        .valid (free_valid_s)
    );

    assign sv_elig_s  = sv_mask[sv_ptr_r] & ~sv_acquired[sv_ptr_r];
    assign tmo_hit_s  = (tmo_cnt_r >= CNT_W'(SEARCH_TIMEOUT - 1));
    assign mask_chg_s = (sv_mask != sv_mask_q_r);

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and one-cycle control strobes for the datapath.
    always_comb begin
        state_s     = state_r;
        pick_s      = 1'b0;
        scan_step_s = 1'b0;
        sv_found_s  = 1'b0;
        sweep_end_s = 1'b0;
        start_ack_s = 1'b0;
        timeout_s   = 1'b0;
        done_ok_s   = 1'b0;
        eval_s      = 1'b0;
        case (state_r)
            IDLE: begin
                // After an empty sweep, wait for a mask change or release.
                if (enable && !sweep_idle) state_s = PICK_CHAN;
                else                       state_s = IDLE;
            end
            PICK_CHAN: begin
                if (!enable) begin
                    state_s = IDLE;
                end else if (free_valid_s) begin
                    pick_s  = 1'b1;
                    state_s = PICK_SV;
                end else begin
                    state_s = PICK_CHAN;
                end
            end
            PICK_SV: begin
                if (!enable) begin
                    state_s = IDLE;
                end else if (sv_elig_s) begin
                    sv_found_s = 1'b1;
                    state_s    = START;
                end else if (scan_cnt_r == sv_t'(NUM_SV - 1)) begin
                    sweep_end_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    scan_step_s = 1'b1;
                    state_s     = PICK_SV;
                end
            end
            START: begin
                if (tmo_hit_s) begin
                    timeout_s = 1'b1;
                    state_s   = PICK_CHAN;
                end else if (search_busy) begin
                    start_ack_s = 1'b1;
                    state_s     = WAIT_DONE;
                end else begin
                    state_s = START;
                end
            end
            WAIT_DONE: begin
                if (search_done && (search_channel_in == search_channel)) begin
                    done_ok_s = 1'b1;
                    state_s   = EVAL;
                end else if (tmo_hit_s) begin
                    timeout_s = 1'b1;
                    state_s   = PICK_CHAN;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            EVAL: begin
                eval_s  = 1'b1;
                state_s = PICK_CHAN;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Release masks and acquisition set masks; a release and a hit never hit the same channel.
    always_comb begin
        rel_s    = chan_release & chan_alloc;
        sv_clr_s = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (rel_s[k]) sv_clr_s = sv_clr_s | ({{(NUM_SV-1){1'b0}}, 1'b1} << chan_sv_r[k]);
            else          sv_clr_s = sv_clr_s;
        end
        acq_hit_s   = eval_s && (corr_r >= corr_threshold);
        alloc_set_s = acq_hit_s ? ({{(NUM_CHANNELS-1){1'b0}}, 1'b1} << target_r) : '0;
        sv_set_s    = acq_hit_s ? ({{(NUM_SV-1){1'b0}}, 1'b1} << search_sv) : '0;
    end

    // Datapath: pointer, handshake, timeout, allocation tables and reporting.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            target_r       <= 6'd0;
            sv_ptr_r       <= sv_t'(0);
            scan_cnt_r     <= sv_t'(0);
            tmo_cnt_r      <= '0;
            corr_r         <= 32'd0;
            enable_q_r     <= 1'b0;
            sv_mask_q_r    <= '0;
            search_start   <= 1'b0;
            search_sv      <= sv_t'(0);
            search_channel <= 6'd0;
            chan_alloc     <= '0;
            sv_acquired    <= '0;
            acq_valid      <= 1'b0;
            acq_sv         <= sv_t'(0);
            acq_channel    <= 6'd0;
            acq_corr       <= 32'd0;
            timeout_err    <= 1'b0;
            sweep_idle     <= 1'b0;
            busy           <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) chan_sv_r[k] <= sv_t'(0);
        end else begin
            enable_q_r  <= enable;
            sv_mask_q_r <= sv_mask;
            busy        <= (state_s != IDLE);
            acq_valid   <= 1'b0;
            chan_alloc  <= (chan_alloc & ~rel_s) | alloc_set_s;
            sv_acquired <= (sv_acquired & ~sv_clr_s) | sv_set_s;

            if (pick_s) begin
                target_r   <= free_idx_s;
                scan_cnt_r <= sv_t'(0);
            end
            if (scan_step_s || sweep_end_s) begin
                sv_ptr_r   <= sv_next(sv_ptr_r, NUM_SV);
                scan_cnt_r <= scan_cnt_r + sv_t'(1);
            end
            if (sv_found_s) begin
                search_sv      <= sv_ptr_r;
                search_channel <= target_r;
                sv_ptr_r       <= sv_next(sv_ptr_r, NUM_SV);
                search_start   <= 1'b1;
                tmo_cnt_r      <= '0;
            end else if ((state_r == START) || (state_r == WAIT_DONE)) begin
                if (tmo_cnt_r != {CNT_W{1'b1}}) tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            end
            if (start_ack_s || timeout_s) search_start <= 1'b0;

            if (timeout_s)                   timeout_err <= 1'b1;
            else if (enable_q_r && !enable)  timeout_err <= 1'b0;

            if (mask_chg_s || (|chan_release)) sweep_idle <= 1'b0;
            else if (sweep_end_s)              sweep_idle <= 1'b1;
            else if (sv_found_s)               sweep_idle <= 1'b0;

            if (done_ok_s) corr_r <= search_corr;
            if (acq_hit_s) begin
                acq_valid   <= 1'b1;
                acq_sv      <= search_sv;
                acq_channel <= target_r;
                acq_corr    <= corr_r;
            end
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (acq_hit_s && (target_r == 6'(k))) chan_sv_r[k] <= search_sv;
            end
        end
    end

endmodule

// File: tb/tb_gnss_acq_scheduler.sv
// Directed bench for gnss_acq_scheduler with a hand-driven search engine.
module tb_gnss_acq_scheduler;
    import common_gnss_types_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic [31:0] sv_mask;
    logic [31:0] corr_threshold;
    logic [3:0]  chan_release;
    logic        search_busy;
    logic        search_done;
    logic [31:0] search_corr;
    logic [5:0]  search_channel_in;
    logic        search_start;
    sv_t         search_sv;
    logic [5:0]  search_channel;
    logic [3:0]  chan_alloc;
    logic [31:0] sv_acquired;
    logic        acq_valid;
    sv_t         acq_sv;
    logic [5:0]  acq_channel;
    logic [31:0] acq_corr;
    logic        timeout_err;
    logic        sweep_idle;
    logic        busy;

    int checks;
    int failures;

    gnss_acq_scheduler #(
        .NUM_CHANNELS   (4),
        .NUM_SV         (32),
        .SEARCH_TIMEOUT (100)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .enable            (enable),
        .sv_mask           (sv_mask),
        .corr_threshold    (corr_threshold),
        .chan_release      (chan_release),
        .search_busy       (search_busy),
        .search_done       (search_done),
        .search_corr       (search_corr),
        .search_channel_in (search_channel_in),
        .search_start      (search_start),
        .search_sv         (search_sv),
        .search_channel    (search_channel),
        .chan_alloc        (chan_alloc),
        .sv_acquired       (sv_acquired),
        .acq_valid         (acq_valid),
        .acq_sv            (acq_sv),
        .acq_channel       (acq_channel),
        .acq_corr          (acq_corr),
        .timeout_err       (timeout_err),
        .sweep_idle        (sweep_idle),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"},  64'(search_start),   64'd0);
        chk({tag, "_ssv"},    64'(search_sv),      64'd0);
        chk({tag, "_sch"},    64'(search_channel), 64'd0);
        chk({tag, "_alloc"},  64'(chan_alloc),     64'd0);
        chk({tag, "_svacq"},  64'(sv_acquired),    64'd0);
        chk({tag, "_valid"},  64'(acq_valid),      64'd0);
        chk({tag, "_asv"},    64'(acq_sv),         64'd0);
        chk({tag, "_ach"},    64'(acq_channel),    64'd0);
        chk({tag, "_acorr"},  64'(acq_corr),       64'd0);
        chk({tag, "_tmo"},    64'(timeout_err),    64'd0);
        chk({tag, "_sweep"},  64'(sweep_idle),     64'd0);
        chk({tag, "_busy"},   64'(busy),           64'd0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
    endtask

    // Wait (bounded) for a start request, check its SV/channel, optionally acknowledge.
    task automatic serve_start(input int sv, input int ch, input bit ack, input string tag);
        int n = 0;
        while ((search_start !== 1'b1) && (n < 200)) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, 64'(search_start),   64'd1);
        chk({tag, "_sv"},    64'(search_sv),      64'(sv));
        chk({tag, "_ch"},    64'(search_channel), 64'(ch));
        if (ack) begin
            search_busy = 1'b1;
            tick();
            chk({tag, "_startdrop"}, 64'(search_start), 64'd0);
        end
    endtask

    // Return a completion for channel ch and check the resulting acq_valid pulse.
    task automatic serve_finish(input int ch, input int corr, input bit hit, input string tag);
        tick();
        search_done       = 1'b1;
        search_channel_in = 6'(ch);
        search_corr       = 32'(corr);
        tick();
        search_done = 1'b0;
        search_busy = 1'b0;
        tick();
        chk({tag, "_acqv"}, 64'(acq_valid), 64'(hit));
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        nrst              = 1'b0;
        enable            = 1'b0;
        sv_mask           = 32'h0000_0000;
        corr_threshold    = 32'd1000;
        chan_release      = 4'b0000;
        search_busy       = 1'b0;
        search_done       = 1'b0;
        search_corr       = 32'd0;
        search_channel_in = 6'd0;
        repeat (3) tick();
        chk_zero("rst");
        nrst = 1'b1;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);

        // Basic acquisition: SV0 hits on ch0, SV3 misses on ch1.
        sv_mask = 32'h0000_0009;
        enable  = 1'b1;
        serve_start(0, 0, 1'b1, "t1a");
        serve_finish(0, 1500, 1'b1, "t1a");
        chk("t1a_asv",   64'(acq_sv),      64'd0);
        chk("t1a_ach",   64'(acq_channel), 64'd0);
        chk("t1a_acorr", 64'(acq_corr),    64'd1500);
        chk("t1a_alloc", 64'(chan_alloc),  64'h1);
        chk("t1a_svacq", 64'(sv_acquired), 64'h1);
        tick();
        chk("t1a_pulse", 64'(acq_valid), 64'd0);
        serve_start(3, 1, 1'b1, "t1b");
        search_done       = 1'b1;
        search_channel_in = 6'd2;
        search_corr       = 32'd9999;
        tick();
        search_done = 1'b0;
        tick();
        chk("t1b_badtag_busy",  64'(busy),      64'd1);
        chk("t1b_badtag_valid", 64'(acq_valid), 64'd0);
        serve_finish(1, 200, 1'b0, "t1b");
        chk("t1b_alloc", 64'(chan_alloc),  64'h1);
        chk("t1b_svacq", 64'(sv_acquired), 64'h1);
        chk("t1b_asv",   64'(acq_sv),      64'd0);
        enable = 1'b0;
        tick();
        chk("t1_idle", 64'(busy), 64'd0);

        // Channels full, then release ch2 and continue the pointer at SV5.
        sv_mask = 32'h0000_001E;
        do_reset();
        enable = 1'b1;
        serve_start(1, 0, 1'b1, "t2a"); serve_finish(0, 1100, 1'b1, "t2a");
        serve_start(2, 1, 1'b1, "t2b"); serve_finish(1, 1100, 1'b1, "t2b");
        serve_start(3, 2, 1'b1, "t2c"); serve_finish(2, 1100, 1'b1, "t2c");
        serve_start(4, 3, 1'b1, "t2d"); serve_finish(3, 1100, 1'b1, "t2d");
        chk("t2_alloc", 64'(chan_alloc),  64'hF);
        chk("t2_svacq", 64'(sv_acquired), 64'h1E);
        repeat (10) tick();
        chk("t2_park_start", 64'(search_start), 64'd0);
        chk("t2_park_busy",  64'(busy),         64'd1);
        sv_mask      = 32'h0000_003E;
        chan_release = 4'b0100;
        tick();
        chan_release = 4'b0000;
        chk("t2_rel_alloc", 64'(chan_alloc),  64'hB);
        chk("t2_rel_svacq", 64'(sv_acquired), 64'h16);
        serve_start(5, 2, 1'b1, "t2e");
        serve_finish(2, 2000, 1'b1, "t2e");
        chk("t2e_alloc", 64'(chan_alloc),  64'hF);
        chk("t2e_svacq", 64'(sv_acquired), 64'h36);
        chk("t2e_asv",   64'(acq_sv),      64'd5);
        chk("t2e_ach",   64'(acq_channel), 64'd2);
        chan_release = 4'b0011;
        enable       = 1'b0;
        tick();
        chan_release = 4'b0000;
        chk("t2_multi_alloc", 64'(chan_alloc),  64'hC);
        chk("t2_multi_svacq", 64'(sv_acquired), 64'h30);
        chk("t2_multi_busy",  64'(busy),        64'd0);

        // Tie acquires and the pointer wraps 31 -> 0.
        sv_mask = 32'h4000_0000;
        do_reset();
        enable = 1'b1;
        serve_start(30, 0, 1'b1, "t3a");
        sv_mask = 32'h8000_0001;
        serve_finish(0, 300, 1'b0, "t3a");
        serve_start(31, 0, 1'b1, "t3b");
        serve_finish(0, 1000, 1'b1, "t3b");
        chk("t3_asv",   64'(acq_sv),      64'd31);
        chk("t3_acorr", 64'(acq_corr),    64'd1000);
        chk("t3_alloc", 64'(chan_alloc),  64'h1);
        chk("t3_svacq", 64'(sv_acquired), 64'h8000_0000);

        // Timeout on the wrapped SV0 search: engine never responds.
        serve_start(0, 1, 1'b0, "t4a");
        sv_mask = 32'h8000_0021;
        repeat (99) tick();
        chk("t4_pre_tmo",   64'(timeout_err),  64'd0);
        chk("t4_pre_start", 64'(search_start), 64'd1);
        tick();
        chk("t4_tmo",       64'(timeout_err),  64'd1);
        chk("t4_tmo_start", 64'(search_start), 64'd0);
        serve_start(5, 1, 1'b1, "t4b");
        serve_finish(1, 100, 1'b0, "t4b");
        chk("t4_sticky", 64'(timeout_err), 64'd1);
        enable = 1'b0;
        tick();
        chk("t4_clr",  64'(timeout_err), 64'd0);
        chk("t4_idle", 64'(busy),        64'd0);

        // Empty sweep, then a mask change resumes the search.
        sv_mask = 32'h0000_0000;
        do_reset();
        enable = 1'b1;
        repeat (33) tick();
        chk("t5_pre_sweep", 64'(sweep_idle), 64'd0);
        chk("t5_pre_busy",  64'(busy),       64'd1);
        tick();
        chk("t5_sweep",      64'(sweep_idle), 64'd1);
        chk("t5_sweep_busy", 64'(busy),       64'd0);
        repeat (5) tick();
        chk("t5_hold_busy",  64'(busy),         64'd0);
        chk("t5_hold_start", 64'(search_start), 64'd0);
        sv_mask = 32'h0000_0080;
        tick();
        chk("t5_sweep_clr", 64'(sweep_idle), 64'd0);
        serve_start(7, 0, 1'b1, "t5");
        sv_mask = 32'h0000_0280;
        serve_finish(0, 1200, 1'b1, "t5");

        // Enable drops in WAIT_DONE; the allocation still lands, then IDLE.
        serve_start(9, 1, 1'b1, "t6");
        enable = 1'b0;
        serve_finish(1, 5000, 1'b1, "t6");
        chk("t6_alloc", 64'(chan_alloc),  64'h3);
        chk("t6_svacq", 64'(sv_acquired), 64'h280);
        chk("t6_asv",   64'(acq_sv),      64'd9);
        chk("t6_ach",   64'(acq_channel), 64'd1);
        chk("t6_acorr", 64'(acq_corr),    64'd5000);
        tick();
        chk("t6_idle", 64'(busy), 64'd0);

        // Asynchronous reset while a start request is pending.
        sv_mask = 32'h0000_1280;
        enable  = 1'b1;
        serve_start(12, 2, 1'b0, "t7");
        #2 nrst = 1'b0;
        #1;
        chk_zero("arst");
        tick();
        nrst = 1'b1;
        tick();
        chk("t7_after_busy", 64'(busy), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
